edge_detect_multi: RTL

Parametrised, multi-channel successor to the single-input Moore edge detector. Each of `CHANNELS` asynchronous level inputs is synchronised, debounced, and edge-classified under a per-channel runtime mode (rising, falling, both, off). The block emits a one-cycle `tick` per qualified edge and keeps a sticky `pending` flag per channel for software or interrupt logic. It sits between board-level inputs (buttons, switches, external strobes) and the fabric logic clocked by the 33 MHz system clock.

---
 rtl/edge_detect_multi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// ---------------------------------------------------------------------------
// edge_detect_multi
//
// Multi-channel edge detector for board-level inputs. Each channel runs its
// raw level through a synchroniser, a debounce FSM and an edge qualifier
// that is steered by a per-channel runtime mode. Qualified edges produce a
// one-cycle tick and set a sticky pending flag that software clears.
//
// Debounce FSM (per channel):
//   state        | meaning
//   -------------+-----------------------------------------------------
//   STABLE_LOW   | accepted level is 0, synchronised input agrees
//   WAIT_HIGH    | accepted level is 0, input has been 1 for cnt cycles
//   STABLE_HIGH  | accepted level is 1, synchronised input agrees
//   WAIT_LOW     | accepted level is 1, input has been 0 for cnt cycles
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   level      raw asynchronous inputs, one per channel
//   mode       2 bits per channel: 00 off, 01 rise, 10 fall, 11 both
//   clear      per-channel pulse clearing pending
//   stable     debounced level per channel
//   tick       one-cycle pulse per qualified edge
//   pending    sticky event flags
//   event_any  OR of pending
// ---------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     level,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [CHANNELS-1:0]     clear,
    output logic [CHANNELS-1:0]     stable,
    output logic [CHANNELS-1:0]     tick,
    output logic [CHANNELS-1:0]     pending,
    output logic                    event_any
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit 1 of the encoding is the accepted level, so stable decodes
    // straight from the state register without extra logic.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } db_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        db_state_t              state_q;
        db_state_t              state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic [CNT_W-1:0]       cnt_inc;
        logic                   tick_q;
        logic                   tick_d;
        logic                   pending_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], level[i]};
            end
        end

        assign s       = sync_q[SYNC_STAGES-1];
        assign cnt_inc = cnt_q + CNT_ONE;

        // State register, with the tick/pending flops that hang off it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q   <= STABLE_LOW;
                cnt_q     <= '0;
                tick_q    <= 1'b0;
                pending_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                tick_q    <= tick_d;
                // Set takes priority over a coincident clear.
                pending_q <= tick_d | (pending_q & ~clear[i]);
            end
        end

        // Next-state logic.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            unique case (state_q)
                STABLE_LOW: begin
                    if (s) begin
                        if (CNT_LAST == CNT_ONE) begin
                            state_d = STABLE_HIGH;
                        end else begin
                            state_d = WAIT_HIGH;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_d = STABLE_LOW;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = STABLE_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        if (CNT_LAST == CNT_ONE) begin
                            state_d = STABLE_LOW;
                        end else begin
                            state_d = WAIT_LOW;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_d = STABLE_HIGH;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = STABLE_LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = STABLE_LOW;
                end
            endcase
        end

        // Output logic: a flip is a change of the accepted-level bit; the
        // mode is looked at only on that edge.
        always_comb begin
            tick_d = 1'b0;
            if (state_d[1] != state_q[1]) begin
                tick_d = state_d[1] ? mode[2*i] : mode[2*i+1];
            end
        end

        assign stable[i]  = state_q[1];
        assign tick[i]    = tick_q;
        assign pending[i] = pending_q;
    end

    assign event_any = |pending;

endmodule
